fib_seq_gen: RTL
================

Name: fib_seq_gen

Overview:
- Parametrised successor to the fixed 8-bit-in / 32-bit-out Fibonacci engine.
- Computes the n-th term of the Fibonacci or Lucas sequence, with configurable index and result widths, a per-request mode select, and optional overflow saturation.
- Sits behind a valid/ready request port and in front of a valid/ready result port.
- One request is in flight at a time.

Parameters:
- IN_W, 8: width of requested index n.
- OUT_W, 32: width of result term.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fib_in  in  IN_W  requested index n.
- mode_in  in  1  sequence select: 0 = Fibonacci (seeds 0,1), 1 = Lucas (seeds 2,1).
- vld_in  in  1  request valid.
- rdy_in  out  1  ready to accept a request.
- fib_out  out  OUT_W  result term.
- ovf_out  out  1  result exceeded OUT_W bits (only meaningful with FIB_SAT_EN).
- vld_out  out  1  result valid.
- rdy_out  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release): state = IDLE, fib_out = 0, ovf_out = 0, vld_out = 0, rdy_in = 1 (combinational, from state). All internal registers are cleared.
- States: IDLE, CALC, DONE. rdy_in = (state == IDLE).
- IDLE: on an edge with vld_in & rdy_in:
  - load a = seed0, b = seed1, cnt = fib_in, ovf_a = ovf_b = 0;
  - go to CALC.
  - fib_in and mode_in are sampled only on this edge.
- CALC, each edge:
  - If cnt == 0: fib_out <= result(a, ovf_a), ovf_out <= ovf_a, vld_out <= 1, go to DONE.
  - Else: a <= b, ovf_a <= ovf_b; b <= (a + b) mod 2^OUT_W; ovf_b <= ovf_a | ovf_b | carry(a + b); cnt <= cnt - 1.
- Latency: vld_out rises n+1 edges after the accept edge (n = 0 -> 1 edge; n = 255 -> 256 edges). Throughput is one request per n+3 cycles.
- DONE: fib_out and ovf_out are held stable while vld_out & !rdy_out.
  - On an edge with vld_out & rdy_out: vld_out <= 0, go to IDLE.
  - rdy_in rises the cycle after the handshake; there is no same-cycle turnaround.
- vld_in while not IDLE is ignored; no request is queued.
- The adder is OUT_W+1 bits wide. The carry is tracked per register, so an overflow in the look-ahead term b does not flag a result a that fits.
- Reset asserted mid-CALC or mid-DONE: immediate return to reset values; the pending result is discarded.
- rdy_out is a don't-care outside DONE.

Optional Feature:
- FIB_SAT_EN defined: when ovf_a is set at completion, fib_out = all ones and ovf_out = 1.
- FIB_SAT_EN undefined: fib_out = a (wraps modulo 2^OUT_W), ovf_out is tied to 0, and the ovf_a/ovf_b flops are not built.

Decomposition:
- fib_pkg holds:
  - state enum fib_state_e {IDLE, CALC, DONE};
  - mode constants FIB_MODE_FIB = 1'b0, FIB_MODE_LUCAS = 1'b1;
  - seed constants FIB_SEED0 = 0, FIB_SEED1 = 1, LUCAS_SEED0 = 2, LUCAS_SEED1 = 1.
- One natural sub-module: fib_step.
  - Combinational OUT_W adder with carry-out and next-flag logic.
  - Instantiated once in the top-level FSM/register block.

Test Plan:
- Mode 0, n = 6, rdy_out held 0 for 2 cycles, then 1 -> vld_out at accept+7 edges; fib_out = 8, held stable until the handshake; rdy_in returns 1 the cycle after.
- Mode 1 (Lucas), n = 5 -> fib_out = 11. Then n = 0 in both modes -> 2 and 0, each with vld_out 1 edge after accept.
- OUT_W = 32, mode 0, n = 47 -> fib_out = 2971215073, ovf_out = 0 (b overflowed, a did not).
- OUT_W = 32, mode 0, n = 48:
  - FIB_SAT_EN defined -> fib_out = 32'hFFFF_FFFF, ovf_out = 1;
  - FIB_SAT_EN undefined -> fib_out = 512559680, ovf_out = 0.
- Pulse vld_in with n = 3 during CALC of an n = 10 request -> ignored; only fib_out = 55 is produced, with exactly one vld_out pulse.
- Assert rst_n = 0 mid-CALC (n = 20, after 5 cycles) -> vld_out = 0, fib_out = 0, rdy_in = 1 at once. A new n = 6 request then yields 8.

Source files
------------

// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_pkg
// Description : Shared FSM state type, mode encodings and sequence seeds.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fib_state_e;

    localparam logic FIB_MODE_FIB   = 1'b0;
    localparam logic FIB_MODE_LUCAS = 1'b1;

    localparam int unsigned FIB_SEED0   = 0;
    localparam int unsigned FIB_SEED1   = 1;
    localparam int unsigned LUCAS_SEED0 = 2;
    localparam int unsigned LUCAS_SEED1 = 1;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_step.sv
`default_nettype none
// ============================================================================
// Module      : fib_step
// Description : One Fibonacci recurrence step, wrapping OUT_W-bit add.
//               With FIB_SAT_EN the carry-out folds into a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_step #(
    parameter int OUT_W = 32
) (
    input  logic [OUT_W-1:0] a,
    input  logic [OUT_W-1:0] b,
`ifdef FIB_SAT_EN
    input  logic             ovf_a,
    input  logic             ovf_b,
    output logic             ovf_next,
`endif
    output logic [OUT_W-1:0] sum
);

`ifdef FIB_SAT_EN
    logic [OUT_W:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b};
    assign sum      = w_full[OUT_W-1:0];
    assign ovf_next = ovf_a | ovf_b | w_full[OUT_W];
`else
    assign sum = a + b;
`endif

endmodule : fib_step
`default_nettype wire

// File: rtl/fib_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : fib_seq_gen
// Description : n-th term of the Fibonacci/Lucas sequence behind valid/ready
//               ports. Define FIB_SAT_EN to saturate and flag overflowed results.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  fib_in,
    input  logic             mode_in,
    input  logic             vld_in,
    output logic             rdy_in,
    output logic [OUT_W-1:0] fib_out,
    output logic             ovf_out,
    output logic             vld_out,
    input  logic             rdy_out
);

    fib_state_e       r_state;
    fib_state_e       w_state_nxt;
    logic [OUT_W-1:0] r_a;
    logic [OUT_W-1:0] r_b;
    logic [IN_W-1:0]  r_cnt;
    logic [OUT_W-1:0] w_sum;
    logic [OUT_W-1:0] w_seed0;
    logic [OUT_W-1:0] w_seed1;
    logic [OUT_W-1:0] w_result;
    logic             w_accept;
    logic             w_cnt_zero;

    assign rdy_in     = (r_state == IDLE);
    assign w_accept   = vld_in & rdy_in;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_seed0    = (mode_in == FIB_MODE_LUCAS) ? OUT_W'(LUCAS_SEED0) : OUT_W'(FIB_SEED0);
    assign w_seed1    = (mode_in == FIB_MODE_LUCAS) ? OUT_W'(LUCAS_SEED1) : OUT_W'(FIB_SEED1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = CALC;
            CALC:    if (w_cnt_zero) w_state_nxt = DONE;
            DONE:    if (rdy_out)    w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

`ifdef FIB_SAT_EN
    logic r_ovf_a;
    logic r_ovf_b;
    logic w_ovf_nxt;

    fib_step #(.OUT_W(OUT_W)) u_step (
        .a        (r_a),
        .b        (r_b),
        .ovf_a    (r_ovf_a),
        .ovf_b    (r_ovf_b),
        .ovf_next (w_ovf_nxt),
        .sum      (w_sum)
    );

    assign w_result = r_ovf_a ? '1 : r_a;

    // Overflow flags shadow a/b so a wrapped look-ahead term never taints a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
            ovf_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ovf_a <= 1'b0;
                        r_ovf_b <= 1'b0;
                    end
                end
                CALC: begin
                    if (w_cnt_zero) begin
                        ovf_out <= r_ovf_a;
                    end else begin
                        r_ovf_a <= r_ovf_b;
                        r_ovf_b <= w_ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    fib_step #(.OUT_W(OUT_W)) u_step (
        .a   (r_a),
        .b   (r_b),
        .sum (w_sum)
    );

    assign w_result = r_a;
    assign ovf_out  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            fib_out <= '0;
            vld_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= w_seed0;
                        r_b   <= w_seed1;
                        r_cnt <= fib_in;
                    end
                end
                CALC: begin
                    if (w_cnt_zero) begin
                        fib_out <= w_result;
                        vld_out <= 1'b1;
                    end else begin
                        r_a   <= r_b;
                        r_b   <= w_sum;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rdy_out) begin
                        vld_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : fib_seq_gen
`default_nettype wire
